i2c_slave_mem: RTL and testbench

Parametrised I2C target with an internal byte register file, replacing the single-byte fixed-timing slave. It detects START, repeated START and STOP from edges of the synchronised SCL/SDA lines rather than from a free-running bit-period counter. It supports a register pointer with auto-increment and multi-byte burst reads and writes. It sits behind the board's open-drain pad logic: the pad drives SDA low when `sda_oe` is 1 and releases it otherwise.

---
 rtl/i2c_slave_mem.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with a byte register file, auto-increment pointer and burst read/write.
// Optional glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
// Ports:
//   clk        system clock (>= 16x SCL)
//   rst_n      synchronous active-low reset
//   scl_in     raw SCL pad input (asynchronous)
//   sda_in     raw SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   busy       high from START until STOP
//   done       one-cycle pulse on STOP ending an addressed transaction
//   ack_err    STOP/START arrived mid-byte in an addressed transaction
//   wr_strobe  one-cycle pulse per committed register write
//   wr_idx     register index written (valid with wr_strobe)
//   wr_data    byte written (valid with wr_strobe)
module i2c_slave_mem #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int MEM_DEPTH = 16,
   localparam int PTR_W = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   output logic             busy,
   output logic             done,
   output logic             ack_err,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_idx,
   output logic [7:0]       wr_data
);
   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] PTR       = 4'd3;
   localparam logic [3:0] PTR_ACK   = 4'd4;
   localparam logic [3:0] WDATA     = 4'd5;
   localparam logic [3:0] WDATA_ACK = 4'd6;
   localparam logic [3:0] RDATA     = 4'd7;
   localparam logic [3:0] RACK      = 4'd8;
   localparam logic [3:0] IGNORE    = 4'd9;

   logic [7:0]       mem [MEM_DEPTH];
   logic [1:0]       scl_s, sda_s;
   logic             scl_l, sda_l, scl_p, sda_p;
   logic [3:0]       state, cnt;
   logic [7:0]       sr, rx_byte;
   logic [PTR_W-1:0] ptr, ptr_inc;
   logic             hit, scl_rise, scl_fall, start, stop, mid_byte;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_f, sda_f;
   // Majority of the current and two previous samples: a 1-clk pulse never wins the vote.
   always_ff @(posedge clk)
      if (!rst_n) begin
         scl_f <= '1;
         sda_f <= '1;
         scl_l <= 1'b1;
         sda_l <= 1'b1;
      end else begin
         scl_f <= {scl_f[0], scl_s[1]};
         sda_f <= {sda_f[0], sda_s[1]};
         scl_l <= (scl_s[1] & scl_f[0]) | (scl_s[1] & scl_f[1]) | (scl_f[0] & scl_f[1]);
         sda_l <= (sda_s[1] & sda_f[0]) | (sda_s[1] & sda_f[1]) | (sda_f[0] & sda_f[1]);
      end
`else
   assign scl_l = scl_s[1];
   assign sda_l = sda_s[1];
`endif

   assign rx_byte  = {sr[6:0], sda_l};
   assign ptr_inc  = ptr + PTR_W'(1);
   assign scl_rise = scl_l & ~scl_p;
   assign scl_fall = ~scl_l & scl_p;
   assign start    = scl_l & scl_p & sda_p & ~sda_l;
   assign stop     = scl_l & scl_p & ~sda_p & sda_l;
   // STOP/START is always preceded by one SCL rise, so completed bits = cnt-1.
   assign mid_byte = hit && (state == PTR || state == WDATA || state == RDATA) && cnt >= 4'd2;

   always_ff @(posedge clk)
      if (!rst_n) begin
         scl_s     <= '1;
         sda_s     <= '1;
         scl_p     <= 1'b1;
         sda_p     <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         ptr       <= '0;
         hit       <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         wr_strobe <= 1'b0;
         wr_idx    <= '0;
         wr_data   <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'(i);
      end else begin
         scl_s     <= {scl_s[0], scl_in};
         sda_s     <= {sda_s[0], sda_in};
         scl_p     <= scl_l;
         sda_p     <= sda_l;
         done      <= 1'b0;
         wr_strobe <= 1'b0;
         if (start) begin
            state   <= ADDR;
            cnt     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
            ack_err <= mid_byte;
         end else if (stop) begin
            state   <= IDLE;
            cnt     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= hit;
            hit     <= 1'b0;
            ack_err <= ack_err | mid_byte;
         end else if (scl_rise) begin
            case (state)
               ADDR, PTR, WDATA: begin
                  sr  <= rx_byte;
                  cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     if (state == ADDR) begin
                        state <= (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                        hit   <= hit | (rx_byte[7:1] == SLAVE_ADDR);
                     end else if (state == PTR) begin
                        ptr   <= rx_byte[PTR_W-1:0];
                        state <= PTR_ACK;
                     end else begin
                        mem[ptr]  <= rx_byte;
                        wr_strobe <= 1'b1;
                        wr_idx    <= ptr;
                        wr_data   <= rx_byte;
                        ptr       <= ptr_inc;
                        state     <= WDATA_ACK;
                     end
                  end
               end
               RDATA: cnt <= cnt + 4'd1;
               RACK:
                  if (sda_l) state <= IGNORE;
                  else begin
                     // Reload on the ACK rise so the next MSB is ready at the following fall.
                     ptr <= ptr_inc;
                     sr  <= mem[ptr_inc];
                     cnt <= 4'd1;
                  end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR_ACK, PTR_ACK, WDATA_ACK:
                  // First fall starts the ACK slot, second fall ends it.
                  if (cnt == 4'd0) begin
                     sda_oe <= 1'b1;
                     cnt    <= 4'd1;
                  end else begin
                     cnt <= '0;
                     if (state == ADDR_ACK && sr[0]) begin
                        state  <= RDATA;
                        sr     <= mem[ptr];
                        sda_oe <= ~mem[ptr][7];
                     end else begin
                        state  <= (state == ADDR_ACK) ? PTR : WDATA;
                        sda_oe <= 1'b0;
                     end
                  end
               RDATA:
                  if (cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= RACK;
                     cnt    <= '0;
                  end else begin
                     sda_oe <= ~sr[6];
                     sr     <= {sr[6:0], 1'b0};
                  end
               RACK:
                  if (cnt == 4'd1) begin
                     sda_oe <= ~sr[7];
                     state  <= RDATA;
                     cnt    <= '0;
                  end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: directed bench for i2c_slave_mem acting as bus master over an open-drain SDA model.
module tb_i2c_slave_mem;
   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe, busy, done, ack_err, wr_strobe;
   logic [3:0] wr_idx;
   logic [7:0] wr_data;
   logic       sda_line;

   int checks = 0;
   int fails = 0;
   int done_cnt = 0;
   logic oe_seen = 1'b0;
   logic [3:0] wlog_i[$];
   logic [7:0] wlog_d[$];

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_mem dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .busy(busy), .done(done), .ack_err(ack_err), .wr_strobe(wr_strobe),
      .wr_idx(wr_idx), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) begin
         wlog_i.push_back(wr_idx);
         wlog_d.push_back(wr_data);
      end
      if (done) done_cnt++;
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      sda_m = b; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      r = sda_line; wait_clk(Q);
      scl = 1'b0; wait_clk(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
      bus_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic m_ack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, r);
         d = {d[6:0], r};
      end
      bus_bit(m_ack, r);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
      wait_clk(4);
      checks++; if ({sda_oe, busy, done, ack_err, wr_strobe} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b expected 00000", {sda_oe, busy, done, ack_err, wr_strobe}); end
      checks++; if (wr_idx !== 4'h0) begin fails++; $display("FAIL reset_wr_idx: got %h expected 0", wr_idx); end
      checks++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
      rst_n = 1'b1;
      wait_clk(4);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_read_reset();
      logic a;
      logic [7:0] d;
      int d0 = done_cnt;
      bus_start();
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rd_busy: got %b expected 1", busy); end
      wr_byte(8'hA1, a);
      checks++; if (a !== 1'b0) begin fails++; $display("FAIL rd_addr_ack: got %b expected 0", a); end
      rd_byte(1'b0, d);
      checks++; if (d !== 8'h00) begin fails++; $display("FAIL rd_b0: got %h expected 00", d); end
      rd_byte(1'b0, d);
      checks++; if (d !== 8'h01) begin fails++; $display("FAIL rd_b1: got %h expected 01", d); end
      rd_byte(1'b1, d);
      checks++; if (d !== 8'h02) begin fails++; $display("FAIL rd_b2: got %h expected 02", d); end
      checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rd_nack_release: got %b expected 0", sda_oe); end
      bus_stop();
      wait_clk(6);
      checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rd_done: got %0d expected 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_write();
      logic [3:0] acks;
      logic a;
      int n0 = wlog_i.size();
      int d0 = done_cnt;
      bus_start();
      wr_byte(8'hA0, a); acks[3] = a;
      wr_byte(8'h03, a); acks[2] = a;
      wr_byte(8'h5A, a); acks[1] = a;
      wr_byte(8'hC3, a); acks[0] = a;
      bus_stop();
      wait_clk(6);
      checks++; if (acks !== 4'b0000) begin fails++; $display("FAIL wr_acks: got %b expected 0000", acks); end
      checks++; if (wlog_i.size() - n0 !== 2) begin fails++; $display("FAIL wr_count: got %0d expected 2", wlog_i.size() - n0); end
      else begin
         checks++; if ({wlog_i[n0], wlog_d[n0]} !== {4'h3, 8'h5A}) begin fails++; $display("FAIL wr_first: got %h/%h expected 3/5a", wlog_i[n0], wlog_d[n0]); end
         checks++; if ({wlog_i[n0+1], wlog_d[n0+1]} !== {4'h4, 8'hC3}) begin fails++; $display("FAIL wr_second: got %h/%h expected 4/c3", wlog_i[n0+1], wlog_d[n0+1]); end
      end
      checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL wr_done: got %0d expected 1", done_cnt - d0); end
      checks++; if (ack_err !== 1'b0) begin fails++; $display("FAIL wr_ack_err: got %b expected 0", ack_err); end
   endtask

   task automatic test_wrap();
      logic a;
      logic [7:0] d;
      bus_start();
      wr_byte(8'hA0, a);
      wr_byte(8'h0F, a);
      checks++; if (a !== 1'b0) begin fails++; $display("FAIL wrap_ptr_ack: got %b expected 0", a); end
      bus_rstart();
      wr_byte(8'hA1, a);
      checks++; if (a !== 1'b0) begin fails++; $display("FAIL wrap_addr_ack: got %b expected 0", a); end
      rd_byte(1'b0, d);
      checks++; if (d !== 8'h0F) begin fails++; $display("FAIL wrap_b0: got %h expected 0f", d); end
      rd_byte(1'b1, d);
      checks++; if (d !== 8'h00) begin fails++; $display("FAIL wrap_b1: got %h expected 00", d); end
      bus_stop();
      wait_clk(6);
      checks++; if (ack_err !== 1'b0) begin fails++; $display("FAIL wrap_ack_err: got %b expected 0", ack_err); end
   endtask

   task automatic test_mismatch();
      logic a;
      int d0 = done_cnt;
      oe_seen = 1'b0;
      bus_start();
      wr_byte(8'hA2, a);
      checks++; if (a !== 1'b1) begin fails++; $display("FAIL mm_ack: got %b expected 1", a); end
      bus_stop();
      wait_clk(6);
      checks++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL mm_oe_seen: got %b expected 0", oe_seen); end
      checks++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL mm_done: got %0d expected 0", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mm_busy: got %b expected 0", busy); end
   endtask

   task automatic test_abort();
      logic a, r;
      int n0 = wlog_i.size();
      bus_start();
      wr_byte(8'hA0, a);
      wr_byte(8'h07, a);
      wr_byte(8'h11, a);
      bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
      bus_stop();
      wait_clk(6);
      checks++; if (ack_err !== 1'b1) begin fails++; $display("FAIL ab_ack_err: got %b expected 1", ack_err); end
      checks++; if (wlog_i.size() - n0 !== 1) begin fails++; $display("FAIL ab_wr_count: got %0d expected 1", wlog_i.size() - n0); end
      else begin
         checks++; if ({wlog_i[n0], wlog_d[n0]} !== {4'h7, 8'h11}) begin fails++; $display("FAIL ab_wr: got %h/%h expected 7/11", wlog_i[n0], wlog_d[n0]); end
      end
      bus_start();
      checks++; if (ack_err !== 1'b0) begin fails++; $display("FAIL ab_clear: got %b expected 0", ack_err); end
      bus_stop();
      wait_clk(6);
   endtask

   task automatic test_reset_mid();
      logic a;
      logic [7:0] d;
      bus_start();
      wr_byte(8'hA0, a);
      wr_byte(8'h00, a);
      bus_rstart();
      wr_byte(8'hA1, a);
      checks++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rm_drive0: got %b expected 1", sda_oe); end
      rst_n = 1'b0;
      wait_clk(1);
      checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rm_release: got %b expected 0", sda_oe); end
      checks++; if ({busy, done, ack_err, wr_strobe, wr_idx, wr_data} !== 16'h0) begin fails++; $display("FAIL rm_outputs: got %h expected 0000", {busy, done, ack_err, wr_strobe, wr_idx, wr_data}); end
      sda_m = 1'b1; wait_clk(2);
      scl = 1'b1; wait_clk(4);
      rst_n = 1'b1; wait_clk(4);
      bus_start();
      wr_byte(8'hA0, a);
      wr_byte(8'h03, a);
      bus_rstart();
      wr_byte(8'hA1, a);
      rd_byte(1'b0, d);
      checks++; if (d !== 8'h03) begin fails++; $display("FAIL rm_mem3: got %h expected 03", d); end
      rd_byte(1'b0, d);
      checks++; if (d !== 8'h04) begin fails++; $display("FAIL rm_mem4: got %h expected 04", d); end
      rd_byte(1'b0, d); rd_byte(1'b0, d); rd_byte(1'b1, d);
      checks++; if (d !== 8'h07) begin fails++; $display("FAIL rm_mem7: got %h expected 07", d); end
      bus_stop();
      wait_clk(6);
   endtask

   initial begin
      test_reset();
      test_read_reset();
      test_write();
      test_wrap();
      test_mismatch();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
